// File: rtl/audio_i2s_tx.sv
// I2S transmitter: serialises one stereo sample pair per frame, MSB first, with the
// one-bit delay after each word-select edge, and paces its sample source with req/end pulses.
module audio_i2s_tx #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned SLOT_BITS  = 32,
    parameter int unsigned BCLK_HALF  = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] audio_left,
    input  logic [DATA_WIDTH-1:0] audio_right,
    output logic                  sample_req,
    output logic                  sample_end,
    output logic                  aud_bclk,
    output logic                  aud_daclrck,
    output logic                  aud_dacdat
);

    localparam int unsigned PhaseCnt  = 2 * BCLK_HALF;
    localparam int unsigned FrameBits = 2 * SLOT_BITS;
    localparam int unsigned PW        = $clog2(PhaseCnt);
    localparam int unsigned BW        = $clog2(FrameBits);

    localparam logic [PW-1:0] PhaseLast = PW'(PhaseCnt - 1);
    localparam logic [PW-1:0] PhaseHigh = PW'(BCLK_HALF);
    localparam logic [BW-1:0] BitLast   = BW'(FrameBits - 1);
    localparam logic [BW-1:0] SlotLen   = BW'(SLOT_BITS);
    localparam logic [BW-1:0] DataLen   = BW'(DATA_WIDTH);

    typedef enum logic [1:0] {StIdle, StPrime, StRun} state_t;

    state_t                r_state;
    logic [PW-1:0]         r_phase;
    logic [BW-1:0]         r_bit;
    logic [DATA_WIDTH-1:0] r_shift_l;
    logic [DATA_WIDTH-1:0] r_shift_r;
    logic                  r_go;
    logic                  r_sample_req;
    logic                  r_sample_end;
    logic                  r_bclk;
    logic                  r_lrck;
    logic                  r_dat;

    logic [PW-1:0] w_phase_inc;
    logic [BW-1:0] w_next_bit;
    logic [BW-1:0] w_next_pos;
    logic          w_next_right;
    logic          w_next_data;
    logic          w_phase_last;
    logic          w_bit_last;
    logic          w_frame_start;
    logic          w_frame_stop;

    always_comb begin
        w_phase_inc   = r_phase + 1'b1;
        w_next_bit    = r_bit + 1'b1;
        w_next_right  = (w_next_bit >= SlotLen);
        w_next_pos    = w_next_right ? (w_next_bit - SlotLen) : w_next_bit;
        // Slot position 0 carries the I2S one-bit delay; data fills positions 1..DATA_WIDTH.
        w_next_data   = (w_next_pos != '0) && (w_next_pos <= DataLen);
        w_phase_last  = (r_phase == PhaseLast);
        w_bit_last    = (r_bit == BitLast);
        w_frame_start = w_phase_last &&
                        ((r_state == StPrime) || ((r_state == StRun) && w_bit_last && r_go));
        w_frame_stop  = w_phase_last && (r_state == StRun) && w_bit_last && !r_go;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= StIdle;
            r_phase      <= '0;
            r_bit        <= '0;
            r_shift_l    <= '0;
            r_shift_r    <= '0;
            r_go         <= 1'b0;
            r_sample_req <= 1'b0;
            r_sample_end <= 1'b0;
            r_bclk       <= 1'b0;
            r_lrck       <= 1'b0;
            r_dat        <= 1'b0;
        end else begin
            r_sample_req <= 1'b0;
            r_sample_end <= 1'b0;
            if (w_frame_start) begin
                r_state      <= StRun;
                r_phase      <= '0;
                r_bit        <= '0;
                r_go         <= 1'b0;
                r_shift_l    <= audio_left;
                r_shift_r    <= audio_right;
                r_sample_end <= 1'b1;
                r_bclk       <= 1'b0;
                r_lrck       <= 1'b0;
                r_dat        <= 1'b0;
            end else if (w_frame_stop) begin
                r_state   <= StIdle;
                r_phase   <= '0;
                r_bit     <= '0;
                r_shift_l <= '0;
                r_shift_r <= '0;
                r_bclk    <= 1'b0;
                r_lrck    <= 1'b0;
                r_dat     <= 1'b0;
            end else begin
                case (r_state)
                    StIdle: begin
                        r_phase <= '0;
                        r_bit   <= '0;
                        if (enable) begin
                            r_state      <= StPrime;
                            r_sample_req <= 1'b1;
                        end
                    end
                    StPrime: begin
                        r_phase <= w_phase_inc;
                    end
                    StRun: begin
                        if (w_phase_last) begin
                            r_phase <= '0;
                            r_bit   <= w_next_bit;
                            r_bclk  <= 1'b0;
                            r_lrck  <= w_next_right;
                            if (!w_next_data) begin
                                r_dat <= 1'b0;
                            end else if (w_next_right) begin
                                r_dat     <= r_shift_r[DATA_WIDTH-1];
                                r_shift_r <= r_shift_r << 1;
                            end else begin
                                r_dat     <= r_shift_l[DATA_WIDTH-1];
                                r_shift_l <= r_shift_l << 1;
                            end
                            // Last bit of the frame: the only point where enable is honoured.
                            if (w_next_bit == BitLast) begin
                                r_sample_req <= enable;
                                r_go         <= enable;
                            end
                        end else begin
                            r_phase <= w_phase_inc;
                            if (w_phase_inc == PhaseHigh) begin
                                r_bclk <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign sample_req  = r_sample_req;
    assign sample_end  = r_sample_end;
    assign aud_bclk    = r_bclk;
    assign aud_daclrck = r_lrck;
    assign aud_dacdat  = r_dat;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: a random sample source feeds a scoreboard queue; a monitor
// reassembles each serial frame on BCLK rises and compares it against a frame model.
module tb_audio_i2s_tx;

    localparam int DW = 16;
    localparam int SB = 32;
    localparam int BH = 2;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
    } pair_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] audio_left = '0;
    logic [15:0] audio_right = '0;
    logic        sample_req;
    logic        sample_end;
    logic        aud_bclk;
    logic        aud_daclrck;
    logic        aud_dacdat;
    logic [4:0]  outs;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    frames_checked = 0;
    pair_t exp_q[$];

    int          fixed_req = 0;
    logic [15:0] fixed_l = '0;
    logic [15:0] fixed_r = '0;
    int          chg_req = 0;
    int          chg_bit = 0;

    audio_i2s_tx #(
        .DATA_WIDTH(DW),
        .SLOT_BITS (SB),
        .BCLK_HALF (BH)
    ) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .audio_left (audio_left),
        .audio_right(audio_right),
        .sample_req (sample_req),
        .sample_end (sample_end),
        .aud_bclk   (aud_bclk),
        .aud_daclrck(aud_daclrck),
        .aud_dacdat (aud_dacdat)
    );

    assign outs = {sample_req, sample_end, aud_bclk, aud_daclrck, aud_dacdat};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s got=timeout exp=event (cycle %0d)", name, cyc);
    endtask

    // Frame bit k: slot k/32, position k%32; position p in 1..16 carries sample bit 16-p.
    function automatic logic [63:0] frame_model(input logic [15:0] l, input logic [15:0] r);
        logic [63:0] v;
        logic [15:0] s;
        int          pos;
        v = '0;
        for (int k = 0; k < 2 * SB; k++) begin
            pos = k % SB;
            s   = (k < SB) ? l : r;
            if (pos >= 1 && pos <= DW) v[k] = s[DW - pos];
        end
        return v;
    endfunction

    task automatic wait_req(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sample_req) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) fail_now("wait_sample_req");
    endtask

    task automatic wait_end(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sample_end) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) fail_now("wait_sample_end");
    endtask

    // Returns on the negedge where sample_end is high (first cycle of bit 0).
    task automatic do_startup(input logic [15:0] l, input logic [15:0] r);
        int bad;
        fixed_l = l;
        fixed_r = r;
        fixed_req++;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        check("startup_req_next_cycle", sample_req, 1);
        bad = 0;
        for (int k = 1; k <= 2 * BH; k++) begin
            @(negedge clk);
            if (aud_bclk || (k < 2 * BH && (sample_end || sample_req))) bad++;
        end
        check("prime_quiet", bad, 0);
        check("startup_end_after_prime", sample_end, 1);
    endtask

    // Sample source: answers every sample_req and records what the next frame must carry.
    initial begin : source
        int          scyc;
        int          fixed_ack;
        int          chg_ack;
        bit          keep;
        logic [15:0] cl;
        logic [15:0] cr;
        pair_t       p;
        scyc = -1;
        fixed_ack = 0;
        chg_ack = 0;
        keep = 1'b0;
        cl = '0;
        cr = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                scyc = -1;
            end else begin
                if (sample_end) scyc = 0;
                else if (scyc >= 0) scyc++;
                if (sample_req) begin
                    if (fixed_req != fixed_ack) begin
                        cl = fixed_l;
                        cr = fixed_r;
                        fixed_ack = fixed_req;
                    end else if (!keep) begin
                        cl = 16'($urandom);
                        cr = 16'($urandom);
                    end
                    keep = 1'b0;
                    audio_left  = cl;
                    audio_right = cr;
                    p.l = cl;
                    p.r = cr;
                    exp_q.push_back(p);
                end
                if (chg_req != chg_ack && scyc == chg_bit * 2 * BH + 1) begin
                    cl = cl ^ (16'($urandom) | 16'h0001);
                    cr = cr ^ (16'($urandom) | 16'h0100);
                    audio_left  = cl;
                    audio_right = cr;
                    keep = 1'b1;
                    chg_ack = chg_req;
                end
            end
        end
    end

    initial begin : monitor
        bit          in_frame;
        bit          req_pending;
        int          req_cyc;
        int          fcyc;
        int          nbits;
        int          shape_err;
        logic [63:0] gdat;
        logic [63:0] glr;
        logic [63:0] ev;
        logic        prev_bclk;
        logic        prev_dat;
        logic        prev_lr;
        pair_t       e;
        in_frame = 1'b0;
        req_pending = 1'b0;
        req_cyc = 0;
        fcyc = 0;
        nbits = 0;
        shape_err = 0;
        gdat = '0;
        glr = '0;
        prev_bclk = 1'b0;
        prev_dat = 1'b0;
        prev_lr = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                in_frame = 1'b0;
                req_pending = 1'b0;
                exp_q.delete();
            end else begin
                if (sample_req || sample_end) begin
                    check("req_end_exclusive", sample_req & sample_end, 0);
                end
                if (sample_req) begin
                    req_pending = 1'b1;
                    req_cyc = cyc;
                end
                if (sample_end) begin
                    check("end_has_pending_req", req_pending, 1);
                    if (req_pending) check("req_to_end_spacing", cyc - req_cyc, 2 * BH);
                    req_pending = 1'b0;
                    in_frame = 1'b1;
                    fcyc = 0;
                    nbits = 0;
                    shape_err = 0;
                end
                if (in_frame) begin
                    if (aud_bclk != ((fcyc % (2 * BH)) >= BH)) shape_err++;
                    if ((fcyc % (2 * BH)) != 0 &&
                        (aud_dacdat != prev_dat || aud_daclrck != prev_lr)) shape_err++;
                    if (aud_bclk && !prev_bclk) begin
                        gdat[nbits] = aud_dacdat;
                        glr[nbits]  = aud_daclrck;
                        nbits++;
                    end
                    if (nbits == 2 * SB) begin
                        in_frame = 1'b0;
                        if (exp_q.size() == 0) begin
                            fail_now("scoreboard_underflow");
                        end else begin
                            e  = exp_q.pop_front();
                            ev = frame_model(e.l, e.r);
                            check("left_slot", gdat[31:0], ev[31:0]);
                            check("right_slot", gdat[63:32], ev[63:32]);
                            check("lrck_pattern", glr, 64'hFFFF_FFFF_0000_0000);
                            check("bclk_and_edge_shape", shape_err, 0);
                            frames_checked++;
                        end
                    end
                    fcyc++;
                end
            end
            prev_bclk = aud_bclk;
            prev_dat  = aud_dacdat;
            prev_lr   = aud_daclrck;
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog got=running exp=finished (cycle %0d)", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin : main
        int t0;
        int t1;
        int cnt;
        int bad;
        int fc;
        repeat (3) @(negedge clk);
        check("reset_outputs", outs, 0);
        #1 reset_n = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (outs != 0) cnt++;
        end
        check("idle_quiet", cnt, 0);

        do_startup(16'h8001, 16'h7FFE);

        // Streaming with a fresh random pair per request.
        wait_req(300, t0);
        for (int i = 0; i < 3; i++) begin
            wait_req(300, t1);
            if (t0 >= 0 && t1 >= 0) check("stream_req_period", t1 - t0, 4 * SB * BH);
            t0 = t1;
        end

        // Inputs change at bit 10: current frame unaffected, new pair appears next frame.
        wait_end(300, t0);
        chg_bit = 10;
        chg_req++;
        wait_end(300, t0);
        wait_end(300, t0);

        // One-cycle enable glitch at bit 20 is ignored.
        wait_end(300, t0);
        repeat (20 * 2 * BH) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        wait_req(300, t1);
        if (t0 >= 0 && t1 >= 0) check("glitch_req_position", t1 - t0, (2 * SB - 1) * 2 * BH);
        wait_end(300, t1);
        if (t0 >= 0 && t1 >= 0) check("glitch_frame_period", t1 - t0, 4 * SB * BH);

        // Stop: enable dropped at bit 40 of this frame.
        fc = frames_checked;
        repeat (40 * 2 * BH) @(negedge clk);
        enable = 1'b0;
        cnt = 0;
        bad = 0;
        for (int k = 40 * 2 * BH + 1; k <= 300; k++) begin
            @(negedge clk);
            if (sample_req) cnt++;
            if (k >= 4 * SB * BH && outs != 0) bad++;
        end
        check("stop_no_req", cnt, 0);
        check("stop_outputs_idle", bad, 0);
        check("stop_frame_completed", frames_checked - fc, 1);

        do_startup(16'h8001, 16'h7FFE);

        // Asynchronous reset mid right slot while BCLK is high.
        repeat ((SB + 2) * 2 * BH + BH) @(negedge clk);
        check("pre_reset_bclk_lrck", {aud_bclk, aud_daclrck}, 2'b11);
        #1 reset_n = 1'b0;
        enable = 1'b0;
        #1 check("reset_async_outputs", outs, 0);
        repeat (3) @(negedge clk);
        check("reset_held_outputs", outs, 0);
        #1 reset_n = 1'b1;
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (outs != 0) cnt++;
        end
        check("post_reset_quiet", cnt, 0);

        do_startup(16'($urandom), 16'($urandom));
        wait_end(300, t0);
        wait_end(300, t0);
        repeat (10) @(negedge clk);
        enable = 1'b0;
        repeat (300) @(negedge clk);
        check("final_outputs_idle", outs, 0);
        check("scoreboard_drained", exp_q.size(), 0);
        check("enough_frames_checked", frames_checked >= 8, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
